// File: rtl/wormhole_teleport.sv
// rtl/wormhole_teleport.sv - wormhole collision edge detect, per-object cooldown and one-hot teleport request FSM
// Ship (0), S1 (1) and S2 (2) share a single request/acknowledge channel; lower index wins arbitration.
module wormhole_teleport #(
  parameter logic [10:0] WH1_EXIT_X   = 11'd120,
  parameter logic [10:0] WH1_EXIT_Y   = 11'd80,
  parameter logic [10:0] WH2_EXIT_X   = 11'd500,
  parameter logic [10:0] WH2_EXIT_Y   = 11'd380,
  parameter logic [1:0]  COOLDOWN_SEC = 2'd2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        oneSec,
  input  logic        collision_Wormhole1_Updated,
  input  logic        collision_Wormhole2_Updated,
  input  logic        S1_collision_Wormhole1_Updated,
  input  logic        S1_collision_Wormhole2_Updated,
  input  logic        S2_collision_Wormhole1_Updated,
  input  logic        S2_collision_Wormhole2_Updated,
  input  logic [2:0]  teleport_ack,
  output logic [2:0]  teleport_req,
  output logic [10:0] teleport_X,
  output logic [10:0] teleport_Y,
  output logic        teleport_drop,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          state_q;
  logic [5:0]      coll_in;
  logic [5:0]      coll_q;
  logic            armed_q;
  logic [5:0]      rise;
  logic [2:0]      pending_q, pending_d;
  logic [2:0]      dest_wh1_q, dest_wh1_d;
  logic [2:0][1:0] cooldown_q, cooldown_d;
  logic [2:0]      accept;
  logic [2:0]      clr_mask;
  logic [1:0]      sel_q;
  logic [1:0]      arb_sel;
  logic [1:0]      tmo_q;
  logic            ack_sel;
  logic            tmo_done;
  logic [2:0]      req_q;
  logic [10:0]     x_q, y_q;
  logic            drop_q;

  // Bit 2*i is wormhole 1 and bit 2*i+1 is wormhole 2 for object i.
  assign coll_in = {S2_collision_Wormhole2_Updated, S2_collision_Wormhole1_Updated,
                    S1_collision_Wormhole2_Updated, S1_collision_Wormhole1_Updated,
                    collision_Wormhole2_Updated,    collision_Wormhole1_Updated};

  // armed_q stays low for the first edge after reset so a level already high is not taken as a rise.
  assign rise     = armed_q ? (coll_in & ~coll_q) : 6'd0;
  assign ack_sel  = teleport_ack[sel_q];
  assign tmo_done = oneSec && (tmo_q == 2'd1);

  always_comb begin
    accept     = 3'd0;
    dest_wh1_d = dest_wh1_q;
    clr_mask   = 3'd0;
    cooldown_d = cooldown_q;
    arb_sel    = 2'd0;
    if (state_q == S_REQ && (ack_sel || tmo_done))
      clr_mask = 3'b001 << sel_q;
    for (int i = 0; i < 3; i++) begin
      accept[i] = (rise[2*i] || rise[2*i+1]) && !pending_q[i] && (cooldown_q[i] == 2'd0);
      // A wormhole-1 hit exits at wormhole 2, so only a pure wormhole-2 hit selects the WH1 exit.
      if (accept[i])
        dest_wh1_d[i] = !rise[2*i];
      if (state_q == S_REQ && ack_sel && sel_q == 2'(i))
        cooldown_d[i] = COOLDOWN_SEC;
      else if (oneSec && cooldown_q[i] != 2'd0)
        cooldown_d[i] = cooldown_q[i] - 2'd1;
    end
    pending_d = (pending_q & ~clr_mask) | accept;
    if (pending_q[0])
      arb_sel = 2'd0;
    else if (pending_q[1])
      arb_sel = 2'd1;
    else
      arb_sel = 2'd2;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      coll_q     <= 6'd0;
      armed_q    <= 1'b0;
      pending_q  <= 3'd0;
      dest_wh1_q <= 3'd0;
      cooldown_q <= '0;
      sel_q      <= 2'd0;
      tmo_q      <= 2'd0;
      req_q      <= 3'd0;
      x_q        <= 11'd0;
      y_q        <= 11'd0;
      drop_q     <= 1'b0;
    end else begin
      coll_q     <= coll_in;
      armed_q    <= 1'b1;
      pending_q  <= pending_d;
      dest_wh1_q <= dest_wh1_d;
      cooldown_q <= cooldown_d;
      drop_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            state_q <= S_REQ;
            sel_q   <= arb_sel;
            tmo_q   <= 2'd0;
            req_q   <= 3'b001 << arb_sel;
            x_q     <= dest_wh1_q[arb_sel] ? WH1_EXIT_X : WH2_EXIT_X;
            y_q     <= dest_wh1_q[arb_sel] ? WH1_EXIT_Y : WH2_EXIT_Y;
          end
        end
        S_REQ: begin
          if (ack_sel || tmo_done) begin
            state_q <= S_IDLE;
            req_q   <= 3'd0;
            x_q     <= 11'd0;
            y_q     <= 11'd0;
            drop_q  <= !ack_sel;
          end else if (oneSec) begin
            tmo_q <= tmo_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign teleport_req  = req_q;
  assign teleport_X    = x_q;
  assign teleport_Y    = y_q;
  assign teleport_drop = drop_q;
  assign busy          = (state_q == S_REQ);

endmodule

// File: tb/tb_wormhole_teleport.sv
// tb/tb_wormhole_teleport.sv - directed self-checking bench for wormhole_teleport
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_wormhole_teleport;

  logic        clk = 1'b0;
  logic        resetN;
  logic        oneSec;
  logic        sh_wh1, sh_wh2, s1_wh1, s1_wh2, s2_wh1, s2_wh2;
  logic [2:0]  teleport_ack;
  logic [2:0]  teleport_req;
  logic [10:0] teleport_X, teleport_Y;
  logic        teleport_drop;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wormhole_teleport dut (
    .clk                            (clk),
    .resetN                         (resetN),
    .oneSec                         (oneSec),
    .collision_Wormhole1_Updated    (sh_wh1),
    .collision_Wormhole2_Updated    (sh_wh2),
    .S1_collision_Wormhole1_Updated (s1_wh1),
    .S1_collision_Wormhole2_Updated (s1_wh2),
    .S2_collision_Wormhole1_Updated (s2_wh1),
    .S2_collision_Wormhole2_Updated (s2_wh2),
    .teleport_ack                   (teleport_ack),
    .teleport_req                   (teleport_req),
    .teleport_X                     (teleport_X),
    .teleport_Y                     (teleport_Y),
    .teleport_drop                  (teleport_drop),
    .busy                           (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sec();
    oneSec = 1'b1;
    tick();
    oneSec = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [2:0] r, input logic [10:0] x, input logic [10:0] y);
    check({tag, "_req"}, 32'(teleport_req), 32'(r));
    check({tag, "_x"}, 32'(teleport_X), 32'(x));
    check({tag, "_y"}, 32'(teleport_Y), 32'(y));
    check({tag, "_busy"}, 32'(busy), 32'(r != 3'd0));
  endtask

  initial begin
    resetN = 1'b0; oneSec = 1'b0; teleport_ack = 3'd0;
    sh_wh1 = 1'b0; sh_wh2 = 1'b0; s1_wh1 = 1'b0; s1_wh2 = 1'b0; s2_wh1 = 1'b0; s2_wh2 = 1'b0;
    tick(2);
    expect_req("rst", 3'd0, 11'd0, 11'd0);
    check("rst_drop", 32'(teleport_drop), 32'd0);
    resetN = 1'b1;
    tick(2);

    // Ship on WH1: request two edges after the rise, ack ends it on the next edge.
    sh_wh1 = 1'b1;
    tick();
    check("lat1_req", 32'(teleport_req), 32'd0);
    tick();
    expect_req("ship", 3'b001, 11'd500, 11'd380);
    tick();
    expect_req("ship_hold", 3'b001, 11'd500, 11'd380);
    teleport_ack = 3'b001;
    tick();
    teleport_ack = 3'd0;
    expect_req("ship_ack", 3'd0, 11'd0, 11'd0);
    sh_wh1 = 1'b0;
    tick();

    // Cooldown: one oneSec leaves 1 and blocks, the second clears it.
    pulse_sec();
    tick();
    sh_wh1 = 1'b1;
    tick(3);
    check("cd_block_req", 32'(teleport_req), 32'd0);
    sh_wh1 = 1'b0;
    tick();
    pulse_sec();
    sh_wh1 = 1'b1;
    tick(2);
    expect_req("cd_clear", 3'b001, 11'd500, 11'd380);
    teleport_ack = 3'b001;
    tick();
    teleport_ack = 3'd0;
    sh_wh1 = 1'b0;
    check("cd_clear_ack", 32'(teleport_req), 32'd0);

    // S1 on WH2 with no ack: foreign ack bits ignored, second oneSec times out.
    s1_wh2 = 1'b1;
    tick(2);
    expect_req("s1", 3'b010, 11'd120, 11'd80);
    teleport_ack = 3'b101;
    tick();
    teleport_ack = 3'd0;
    expect_req("other_ack", 3'b010, 11'd120, 11'd80);
    pulse_sec();
    expect_req("tmo1", 3'b010, 11'd120, 11'd80);
    check("tmo1_drop", 32'(teleport_drop), 32'd0);
    pulse_sec();
    check("tmo2_drop", 32'(teleport_drop), 32'd1);
    expect_req("tmo2", 3'd0, 11'd0, 11'd0);
    tick();
    check("drop_once", 32'(teleport_drop), 32'd0);
    s1_wh2 = 1'b0;
    tick();
    s1_wh2 = 1'b1;
    tick(2);
    expect_req("after_drop", 3'b010, 11'd120, 11'd80);
    teleport_ack = 3'b010;
    tick();
    teleport_ack = 3'd0;
    s1_wh2 = 1'b0;
    check("after_drop_ack", 32'(teleport_req), 32'd0);

    tick();
    pulse_sec();
    tick();
    pulse_sec();
    tick();

    // Ship WH1 and S2 WH2 together: ship first, one idle cycle, then S2.
    sh_wh1 = 1'b1;
    s2_wh2 = 1'b1;
    tick(2);
    expect_req("arb_ship", 3'b001, 11'd500, 11'd380);
    teleport_ack = 3'b001;
    tick();
    teleport_ack = 3'd0;
    expect_req("arb_gap", 3'd0, 11'd0, 11'd0);
    tick();
    expect_req("arb_s2", 3'b100, 11'd120, 11'd80);
    teleport_ack = 3'b100;
    tick();
    teleport_ack = 3'd0;
    sh_wh1 = 1'b0;
    s2_wh2 = 1'b0;
    check("arb_s2_ack", 32'(teleport_req), 32'd0);
    tick();

    // S1 on both wormholes at once: WH1 wins, exit at WH2.
    s1_wh1 = 1'b1;
    s1_wh2 = 1'b1;
    tick(2);
    expect_req("both", 3'b010, 11'd500, 11'd380);
    tick();
    expect_req("both_hold", 3'b010, 11'd500, 11'd380);

    // Asynchronous reset mid-request with inputs held high through release.
    resetN = 1'b0;
    #1;
    expect_req("async_rst", 3'd0, 11'd0, 11'd0);
    check("async_rst_drop", 32'(teleport_drop), 32'd0);
    #2;
    resetN = 1'b1;
    tick();
    check("post_rst_drop", 32'(teleport_drop), 32'd0);
    tick(3);
    check("held_high_req", 32'(teleport_req), 32'd0);
    s1_wh1 = 1'b0;
    s1_wh2 = 1'b0;
    tick();
    s1_wh1 = 1'b1;
    tick(2);
    expect_req("rearm", 3'b010, 11'd500, 11'd380);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
